beam_sweep_controller: RTL and testbench

Sequencer that steers the delay-and-sum beamformer by scanning a fixed set of steering angles. For each angle it drives the four per-mic delay values, discards the beamformer's settling samples, then measures the output energy. After the scan it locks the delays onto the loudest angle. It sits between the top-level control (button/start) and the delay BRAM beamformer, and consumes that block's `audio_out`/`valid_out`.

---
 rtl/beam_sweep_controller.sv | 207 ++++++++++++++++++++
 tb/tb_beam_sweep_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : beam_sweep_controller
// Description : Steers a delay-and-sum beamformer across a fixed set of angles,
//               measures the output energy at each angle after a settling
//               period, then locks the delays onto the loudest angle.
// Revision    : 1.0 - initial release
// ============================================================================
module beam_sweep_controller #(
    parameter int NUM_MICS        = 4,
    parameter int BITS_AUDIO      = 24,
    parameter int NUM_ANGLES      = 16,
    parameter int DELAY_STEP      = 5,
    parameter int SETTLE_SAMPLES  = 16,
    parameter int MEASURE_SAMPLES = 256
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic                                         start_in,
    input  logic                                         beam_valid_in,
    input  logic signed [BITS_AUDIO-1:0]                 beam_audio_in,
    output logic        [7:0]                            delay_1,
    output logic        [7:0]                            delay_2,
    output logic        [7:0]                            delay_3,
    output logic        [7:0]                            delay_4,
    output logic        [$clog2(NUM_ANGLES)-1:0]         cur_angle,
    output logic        [$clog2(NUM_ANGLES)-1:0]         best_angle,
    output logic [BITS_AUDIO+$clog2(MEASURE_SAMPLES)-1:0] best_energy,
    output logic                                         busy,
    output logic                                         sweep_done
);

    localparam int ANG_W  = $clog2(NUM_ANGLES);
    localparam int ACC_W  = BITS_AUDIO + $clog2(MEASURE_SAMPLES);
    localparam int SET_W  = $clog2(SETTLE_SAMPLES + 1);
    localparam int MEAS_W = (MEASURE_SAMPLES > 1) ? $clog2(MEASURE_SAMPLES) : 1;

    localparam logic [SET_W-1:0]  SETTLE_LAST  = SET_W'(SETTLE_SAMPLES - 1);
    localparam logic [MEAS_W-1:0] MEASURE_LAST = MEAS_W'(MEASURE_SAMPLES - 1);
    localparam logic [ANG_W-1:0]  ANGLE_LAST   = ANG_W'(NUM_ANGLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_COMPARE = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    state_t                 state_q,       state_d;
    logic [ANG_W-1:0]       cur_angle_q,   cur_angle_d;
    logic [ANG_W-1:0]       best_angle_q,  best_angle_d;
    logic [ACC_W-1:0]       best_energy_q, best_energy_d;
    logic [ACC_W-1:0]       acc_q,         acc_d;
    logic [SET_W-1:0]       settle_cnt_q,  settle_cnt_d;
    logic [MEAS_W-1:0]      sample_cnt_q,  sample_cnt_d;
    logic [3:0][7:0]        delay_q,       delay_d;
    logic                   busy_q,        busy_d;
    logic                   sweep_done_q,  sweep_done_d;

    logic [BITS_AUDIO-1:0]  audio_raw;
    logic [BITS_AUDIO-1:0]  audio_mag;
    logic                   acc_wins;
    logic [ANG_W-1:0]       winner_angle;

    // Per-mic delay for a steering angle; mics beyond NUM_MICS stay at zero.
    function automatic logic [3:0][7:0] delays_for(input logic [ANG_W-1:0] angle);
        logic [3:0][7:0] d;
        int              prod;
        for (int k = 0; k < 4; k++) begin
            prod = k * int'(angle) * DELAY_STEP;
            d[k] = (k < NUM_MICS) ? 8'(prod) : 8'd0;
        end
        return d;
    endfunction

    assign audio_raw = beam_audio_in;

    // Unsigned magnitude; the most negative code maps exactly to 2^(BITS_AUDIO-1).
    always_comb begin
        audio_mag = audio_raw;
        if (audio_raw[BITS_AUDIO-1]) begin
            audio_mag = ~audio_raw + {{(BITS_AUDIO-1){1'b0}}, 1'b1};
        end
    end

    // Strictly greater wins so that ties keep the earlier (lower) angle.
    assign acc_wins     = (acc_q > best_energy_q);
    assign winner_angle = acc_wins ? cur_angle_q : best_angle_q;

    // Next-state and next-output computation for the sweep sequencer.
    always_comb begin
        state_d       = state_q;
        cur_angle_d   = cur_angle_q;
        best_angle_d  = best_angle_q;
        best_energy_d = best_energy_q;
        acc_d         = acc_q;
        settle_cnt_d  = settle_cnt_q;
        sample_cnt_d  = sample_cnt_q;
        delay_d       = delay_q;
        busy_d        = busy_q;
        sweep_done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOCKED: begin
                if (start_in) begin
                    state_d       = ST_SETTLE;
                    cur_angle_d   = '0;
                    delay_d       = delays_for('0);
                    acc_d         = '0;
                    best_energy_d = '0;
                    best_angle_d  = '0;
                    settle_cnt_d  = '0;
                    sample_cnt_d  = '0;
                    busy_d        = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (beam_valid_in) begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d      = ST_MEASURE;
                        settle_cnt_d = '0;
                        sample_cnt_d = '0;
                        acc_d        = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
            end

            ST_MEASURE: begin
                if (beam_valid_in) begin
                    acc_d = acc_q + ACC_W'(audio_mag);
                    if (sample_cnt_q == MEASURE_LAST) begin
                        state_d      = ST_COMPARE;
                        sample_cnt_d = '0;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end

            ST_COMPARE: begin
                if (acc_wins) begin
                    best_energy_d = acc_q;
                    best_angle_d  = cur_angle_q;
                end
                if (cur_angle_q < ANGLE_LAST) begin
                    state_d      = ST_SETTLE;
                    cur_angle_d  = cur_angle_q + 1'b1;
                    delay_d      = delays_for(cur_angle_q + 1'b1);
                    settle_cnt_d = '0;
                end else begin
                    state_d      = ST_LOCKED;
                    cur_angle_d  = winner_angle;
                    delay_d      = delays_for(winner_angle);
                    busy_d       = 1'b0;
                    sweep_done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset returns everything to idle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            cur_angle_q   <= '0;
            best_angle_q  <= '0;
            best_energy_q <= '0;
            acc_q         <= '0;
            settle_cnt_q  <= '0;
            sample_cnt_q  <= '0;
            delay_q       <= '0;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_angle_q   <= cur_angle_d;
            best_angle_q  <= best_angle_d;
            best_energy_q <= best_energy_d;
            acc_q         <= acc_d;
            settle_cnt_q  <= settle_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            delay_q       <= delay_d;
            busy_q        <= busy_d;
            sweep_done_q  <= sweep_done_d;
        end
    end

    assign delay_1     = delay_q[0];
    assign delay_2     = delay_q[1];
    assign delay_3     = delay_q[2];
    assign delay_4     = delay_q[3];
    assign cur_angle   = cur_angle_q;
    assign best_angle  = best_angle_q;
    assign best_energy = best_energy_q;
    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;

endmodule
`default_nettype wire

// File: tb/tb_beam_sweep_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_beam_sweep_controller
// Description : Self-checking bench for beam_sweep_controller. Per-angle sample
//               sets are generated up front and the winning angle/energy are
//               computed from them by plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beam_sweep_controller;

    localparam int NA   = 4;
    localparam int STEP = 10;
    localparam int NS   = 2;
    localparam int NM   = 8;
    localparam int BA   = 24;
    localparam int AW   = 2;
    localparam int EW   = BA + 3;
    localparam int PER  = NS + NM;

    logic                 clk_in        = 1'b0;
    logic                 rst_in        = 1'b0;
    logic                 start_in      = 1'b0;
    logic                 beam_valid_in = 1'b0;
    logic signed [BA-1:0] beam_audio_in = '0;
    logic [7:0]           delay_1, delay_2, delay_3, delay_4;
    logic [AW-1:0]        cur_angle, best_angle;
    logic [EW-1:0]        best_energy;
    logic                 busy, sweep_done;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [BA-1:0] smp [NA][PER];
    int                   model_angle = 0;
    int                   chg_cnt     = 0;
    logic [31:0]          last_delays = '0;

    beam_sweep_controller #(
        .NUM_MICS        (4),
        .BITS_AUDIO      (BA),
        .NUM_ANGLES      (NA),
        .DELAY_STEP      (STEP),
        .SETTLE_SAMPLES  (NS),
        .MEASURE_SAMPLES (NM)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (start_in),
        .beam_valid_in (beam_valid_in),
        .beam_audio_in (beam_audio_in),
        .delay_1       (delay_1),
        .delay_2       (delay_2),
        .delay_3       (delay_3),
        .delay_4       (delay_4),
        .cur_angle     (cur_angle),
        .best_angle    (best_angle),
        .best_energy   (best_energy),
        .busy          (busy),
        .sweep_done    (sweep_done)
    );

    always #5 clk_in = ~clk_in;

    // Count every change of the delay bus, sampled away from the clock edge.
    always begin
        @(posedge clk_in);
        #2;
        if ({delay_4, delay_3, delay_2, delay_1} != last_delays) begin
            chg_cnt++;
            last_delays = {delay_4, delay_3, delay_2, delay_1};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_delays(input string tag, input int a);
        check({tag, "_d1"}, 64'(delay_1), 64'(0));
        check({tag, "_d2"}, 64'(delay_2), 64'(a * STEP));
        check({tag, "_d3"}, 64'(delay_3), 64'(2 * a * STEP));
        check({tag, "_d4"}, 64'(delay_4), 64'(3 * a * STEP));
    endtask

    function automatic longint mag(input logic signed [BA-1:0] v);
        return (v < 0) ? -longint'(v) : longint'(v);
    endfunction

    task automatic fill(input int mode);
        for (int a = 0; a < NA; a++) begin
            for (int j = 0; j < PER; j++) begin
                case (mode)
                    0: smp[a][j] = (a == 2) ? BA'(100) : ($urandom_range(0, 1) != 0 ? BA'(10) : -BA'(10));
                    1: smp[a][j] = (a == 3) ? BA'(50) : -BA'(50);
                    2: smp[a][j] = (a == 1) ? {1'b1, {(BA-1){1'b0}}} : BA'(int'($urandom_range(0, 2000)) - 1000);
                    3: smp[a][j] = (a == 0) ? ((j < NS) ? BA'(10000) : BA'(1)) : BA'(0);
                    4: smp[a][j] = BA'($urandom);
                    default: smp[a][j] = BA'(int'($urandom_range(0, 6)) - 3);
                endcase
            end
        end
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            beam_valid_in = 1'b1;
            beam_audio_in = BA'($urandom);
            @(posedge clk_in);
            #1;
            beam_valid_in = 1'b0;
            check("idle_busy", 64'(busy), 64'(0));
            check("idle_angle", 64'(cur_angle), 64'(model_angle));
        end
    endtask

    // One full sweep: glitch = pulse index whose idle window carries a stray
    // start; abort = pulse index after which reset is asserted (-1 for none).
    task automatic run_sweep(input int glitch, input int abort);
        longint e, best_e;
        int     best_a, pulse, base_chg, exp_chg;
        best_e = 0;
        best_a = 0;
        for (int a = 0; a < NA; a++) begin
            e = 0;
            for (int j = NS; j < PER; j++) e += mag(smp[a][j]);
            if (e > best_e) begin
                best_e = e;
                best_a = a;
            end
        end

        base_chg = chg_cnt;
        start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_angle", 64'(cur_angle), 64'(0));
        check("start_energy", 64'(best_energy), 64'(0));
        check("start_best", 64'(best_angle), 64'(0));
        check_delays("start", 0);

        pulse = 0;
        for (int a = 0; a < NA; a++) begin
            for (int j = 0; j < PER; j++) begin
                for (int i = 0; i < 3; i++) begin
                    // A valid during the COMPARE cycle must not be counted.
                    beam_valid_in = (i == 0 && j == 0 && a > 0);
                    beam_audio_in = BA'($urandom);
                    if (pulse == glitch && i == 1) start_in = 1'b1;
                    @(posedge clk_in);
                    #1;
                    start_in      = 1'b0;
                    beam_valid_in = 1'b0;
                end
                check("sweep_angle", 64'(cur_angle), 64'(a));
                check("sweep_busy", 64'(busy), 64'(1));
                check_delays("sweep", a);
                beam_valid_in = 1'b1;
                beam_audio_in = smp[a][j];
                if (pulse == abort) begin
                    @(posedge clk_in);
                    #3;
                    rst_in = 1'b1;
                    #1;
                    beam_valid_in = 1'b0;
                    check("rst_angle", 64'(cur_angle), 64'(0));
                    check("rst_best", 64'(best_angle), 64'(0));
                    check("rst_energy", 64'(best_energy), 64'(0));
                    check("rst_busy", 64'(busy), 64'(0));
                    check("rst_done", 64'(sweep_done), 64'(0));
                    check_delays("rst", 0);
                    @(negedge clk_in);
                    rst_in      = 1'b0;
                    model_angle = 0;
                    @(posedge clk_in);
                    #1;
                    check("post_rst_busy", 64'(busy), 64'(0));
                    return;
                end
                @(posedge clk_in);
                #1;
                beam_valid_in = 1'b0;
                pulse++;
            end
        end

        check("cmp_done", 64'(sweep_done), 64'(0));
        check("cmp_busy", 64'(busy), 64'(1));
        @(posedge clk_in);
        #1;
        check("lock_done", 64'(sweep_done), 64'(1));
        check("lock_busy", 64'(busy), 64'(0));
        check("lock_best_angle", 64'(best_angle), 64'(best_a));
        check("lock_best_energy", 64'(best_energy), 64'(best_e));
        check("lock_cur_angle", 64'(cur_angle), 64'(best_a));
        check_delays("lock", best_a);
        exp_chg     = ((model_angle != 0) ? 1 : 0) + (NA - 1) + ((best_a != NA - 1) ? 1 : 0);
        model_angle = best_a;
        @(posedge clk_in);
        #1;
        check("done_pulse", 64'(sweep_done), 64'(0));
        check("lock_hold", 64'(cur_angle), 64'(best_a));
        check("delay_changes", 64'(chg_cnt - base_chg), 64'(exp_chg));
    endtask

    initial begin
        #1;
        rst_in = 1'b1;
        #1;
        check("reset_angle", 64'(cur_angle), 64'(0));
        check("reset_best", 64'(best_angle), 64'(0));
        check("reset_energy", 64'(best_energy), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(sweep_done), 64'(0));
        check_delays("reset", 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        idle_noise(3);

        fill(0); run_sweep(-1, -1);          // peak at angle 2
        fill(1); run_sweep(11, -1);          // ties, stray start in SETTLE of angle 1
        idle_noise(4);
        fill(2); run_sweep(-1, -1);          // most negative sample at angle 1
        fill(3); run_sweep(-1, -1);          // settle samples excluded
        fill(4); run_sweep(-1, 2 * PER + 5); // reset mid-MEASURE at angle 2
        idle_noise(2);
        fill(0); run_sweep(-1, -1);
        for (int r = 0; r < 4; r++) begin
            fill((r % 2 == 0) ? 4 : 5);
            run_sweep(-1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
